// File: rtl/Pipe_Buf_Reg_PKG.sv
// rtl/Pipe_Buf_Reg_PKG.sv - shared types and constants for the data memory arbiter
package Pipe_Buf_Reg_PKG;

    localparam int DMEM_DATA_W         = 32;
    localparam int DMEM_ADDR_W         = 9;
    localparam int DMEM_ARB_STARVE_MAX = 8;
    localparam int DMEM_ARB_STARVE_W   = $clog2(DMEM_ARB_STARVE_MAX + 1);

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_CPU  = 2'd1,
        RS_DBG  = 2'd2
    } rsp_state_t;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [2:0]             funct3;
    } dmem_req_t;

    function automatic int starve_w(input int starve_max);
        return $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating DBG-loss counter that forces a DBG win at STARVE_MAX
import Pipe_Buf_Reg_PKG::*;

module arb_starve_ctr #(
    parameter int STARVE_MAX = DMEM_ARB_STARVE_MAX,
    parameter int W          = DMEM_ARB_STARVE_W
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic force_dbg
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(STARVE_MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_dbg = (cnt == W'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DBG data memory port arbiter; DMEM_ARB_STARVE_EN enables the starvation guard
import Pipe_Buf_Reg_PKG::*;

module dmem_arbiter #(
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int DM_ADDRESS = DMEM_ADDR_W,
    parameter int STARVE_MAX = DMEM_ARB_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_funct3,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_funct3,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    if (STARVE_MAX < 1) begin : g_starve_max_check
        $error("STARVE_MAX must be at least 1");
    end

    dmem_req_t  cpu_bundle;
    dmem_req_t  dbg_bundle;
    dmem_req_t  sel_bundle;
    rsp_state_t rsp_state;
    logic       cpu_win;
    logic       dbg_win;
    logic       force_dbg;

    always_comb begin
        cpu_bundle = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, funct3: cpu_funct3};
        dbg_bundle = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata, funct3: dbg_funct3};
    end

`ifdef DMEM_ARB_STARVE_EN
    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX),
        .W          (starve_w(STARVE_MAX))
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .inc       (dbg_req & ~dbg_win),
        .clr       (~dbg_req | dbg_win),
        .force_dbg (force_dbg)
    );
`else
    assign force_dbg = 1'b0;
`endif

    // Reset masks every grant so nothing reaches memory while the block is held.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (!reset) begin
            if (cpu_req && !(dbg_req && force_dbg)) begin
                cpu_win = 1'b1;
            end else if (dbg_req) begin
                dbg_win = 1'b1;
            end
        end
    end

    always_comb begin
        sel_bundle = '0;
        if (cpu_win) begin
            sel_bundle = cpu_bundle;
        end else if (dbg_win) begin
            sel_bundle = dbg_bundle;
        end
    end

    assign cpu_gnt    = cpu_win;
    assign dbg_gnt    = dbg_win;
    assign cpu_stall  = cpu_req & ~cpu_win & ~reset;
    assign mem_rd     = (cpu_win | dbg_win) & ~sel_bundle.we;
    assign mem_wr     = (cpu_win | dbg_win) & sel_bundle.we;
    assign mem_addr   = sel_bundle.addr;
    assign mem_wdata  = sel_bundle.wdata;
    assign mem_funct3 = sel_bundle.funct3;

    // Tracks who owns the read issued last cycle; writes leave it idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_state <= RS_IDLE;
        end else if (cpu_win && !cpu_we) begin
            rsp_state <= RS_CPU;
        end else if (dbg_win && !dbg_we) begin
            rsp_state <= RS_DBG;
        end else begin
            rsp_state <= RS_IDLE;
        end
    end

    // A read granted just before reset must not surface as a response.
    assign cpu_rvalid = (rsp_state == RS_CPU) & ~reset;
    assign dbg_rvalid = (rsp_state == RS_DBG) & ~reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
import Pipe_Buf_Reg_PKG::*;

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [2:0]  dbg_funct3;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_dbg_win;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W     (32),
        .DM_ADDRESS (9),
        .STARVE_MAX (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_funct3 (cpu_funct3),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_funct3 (dbg_funct3),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = 3'b010;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_funct3 = 3'b010;
        mem_rdata = '0;
        tick();
        // Outputs stay quiet during reset even with both requests up.
        cpu_req = 1; cpu_addr = 9'h0AA; dbg_req = 1; dbg_addr = 9'h0BB;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
        cpu_req = 0; dbg_req = 0;
        tick();
        reset = 1'b0;

        // CPU read alone
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        #1;
        chk("t1_cpu_gnt", cpu_gnt, 1);
        chk("t1_mem_rd", mem_rd, 1);
        chk("t1_mem_addr", mem_addr, 9'h010);
        chk("t1_mem_funct3", mem_funct3, 3'b010);
        chk("t1_cpu_stall", cpu_stall, 0);
        tick();
        cpu_req = 0; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_cpu_rvalid", cpu_rvalid, 1);
        chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t1_dbg_rvalid", dbg_rvalid, 0);
        chk("t1_dbg_rdata", dbg_rdata, 0);
        tick();

        // CPU write collides with DBG read
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h004; cpu_wdata = 32'h12345678;
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h008;
        #1;
        chk("t2_cpu_gnt", cpu_gnt, 1);
        chk("t2_dbg_gnt", dbg_gnt, 0);
        chk("t2_mem_wr", mem_wr, 1);
        chk("t2_mem_rd", mem_rd, 0);
        chk("t2_mem_wdata", mem_wdata, 32'h12345678);
        chk("t2_cpu_stall", cpu_stall, 0);
        tick();
        cpu_req = 0; cpu_we = 0;
        #1;
        chk("t2_dbg_gnt_c1", dbg_gnt, 1);
        chk("t2_mem_rd_c1", mem_rd, 1);
        chk("t2_mem_addr_c1", mem_addr, 9'h008);
        chk("t2_cpu_rvalid_c1", cpu_rvalid, 0);
        tick();
        dbg_req = 0; mem_rdata = 32'hCAFEF00D;
        #1;
        chk("t2_dbg_rvalid", dbg_rvalid, 1);
        chk("t2_dbg_rdata", dbg_rdata, 32'hCAFEF00D);
        chk("t2_cpu_rvalid_c2", cpu_rvalid, 0);
        tick();

        // Back-to-back reads CPU, DBG, CPU
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h020;
        #1;
        chk("t3_cpu_gnt0", cpu_gnt, 1);
        tick();
        cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 9'h024; mem_rdata = 32'h000000A1;
        #1;
        chk("t3_state1", dut.rsp_state, RS_CPU);
        chk("t3_cpu_rv1", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h000000A1});
        chk("t3_dbg_gnt1", dbg_gnt, 1);
        chk("t3_dbg_rv1", dbg_rvalid, 0);
        tick();
        dbg_req = 0; cpu_req = 1; cpu_addr = 9'h028; mem_rdata = 32'h000000B2;
        #1;
        chk("t3_state2", dut.rsp_state, RS_DBG);
        chk("t3_dbg_rv2", {dbg_rvalid, dbg_rdata}, {1'b1, 32'h000000B2});
        chk("t3_cpu_rv2", cpu_rvalid, 0);
        chk("t3_cpu_gnt2", cpu_gnt, 1);
        tick();
        cpu_req = 0; mem_rdata = 32'h000000C3;
        #1;
        chk("t3_state3", dut.rsp_state, RS_CPU);
        chk("t3_cpu_rv3", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h000000C3});
        tick();
        #1;
        chk("t3_state4", dut.rsp_state, RS_IDLE);
        chk("t3_rdata_idle", {cpu_rdata, dbg_rdata}, 0);

        // Both ports requesting continuously
`ifdef DMEM_ARB_STARVE_EN
        exp_dbg_win = 5'b01000;
`else
        exp_dbg_win = 5'b00000;
`endif
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h030;
        dbg_req = 1; dbg_we = 0; dbg_addr = 9'h034;
        mem_rdata = 32'h0000F00D;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_cpu_gnt%0d", i), cpu_gnt, !exp_dbg_win[i]);
            chk($sformatf("t4_dbg_gnt%0d", i), dbg_gnt, exp_dbg_win[i]);
            chk($sformatf("t4_stall%0d", i), cpu_stall, exp_dbg_win[i]);
            if (i > 0) begin
                chk($sformatf("t4_dbg_rv%0d", i), dbg_rvalid, exp_dbg_win[i-1]);
                chk($sformatf("t4_cpu_rv%0d", i), cpu_rvalid, !exp_dbg_win[i-1]);
            end
            tick();
            #1;
        end
        cpu_req = 0; dbg_req = 0;
        tick();

        // Read granted, then reset on the following cycle
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h040;
        #1;
        chk("t5_cpu_gnt", cpu_gnt, 1);
        tick();
        reset = 1; dbg_req = 1; dbg_addr = 9'h048; mem_rdata = 32'h000000DD;
        #1;
        chk("t5_rst_cpu_rvalid", cpu_rvalid, 0);
        chk("t5_rst_cpu_rdata", cpu_rdata, 0);
        chk("t5_rst_gnts", {cpu_gnt, dbg_gnt}, 0);
        chk("t5_rst_mem", {mem_rd, mem_wr, mem_addr, mem_funct3}, 0);
        chk("t5_rst_stall", cpu_stall, 0);
        tick();
        reset = 0; dbg_req = 0; cpu_addr = 9'h044;
        #1;
        chk("t5_post_gnt", cpu_gnt, 1);
        chk("t5_post_addr", mem_addr, 9'h044);
        chk("t5_post_no_rv", cpu_rvalid, 0);
        tick();
        cpu_req = 0; mem_rdata = 32'h000000EE;
        #1;
        chk("t5_post_rv", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h000000EE});
        tick();

        // DBG write alone with byte size code
        dbg_req = 1; dbg_we = 1; dbg_addr = 9'h050; dbg_wdata = 32'h00000055; dbg_funct3 = 3'b000;
        #1;
        chk("t6_dbg_gnt", dbg_gnt, 1);
        chk("t6_mem_wr", mem_wr, 1);
        chk("t6_mem_rd", mem_rd, 0);
        chk("t6_mem_funct3", mem_funct3, 3'b000);
        chk("t6_mem_wdata", mem_wdata, 32'h00000055);
        tick();
        dbg_req = 0; dbg_we = 0;
        #1;
        chk("t6_mem_wr_off", mem_wr, 0);
        chk("t6_no_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
